// File: rtl/card_dealer_pkg.sv
// Shared types and constants for the 24-game card dealer: FSM states,
// card geometry and the 4-bit XNOR LFSR seed/lockup values plus its step.
package dealer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CARD_W    = 4;
  localparam int NUM_CARDS = 4;

  localparam logic [3:0] LFSR_SEED = 4'b1010;
  localparam logic [3:0] LFSR_LOCK = 4'b1111;

  // All-ones is the XNOR lockup point; re-enter the main cycle at the seed.
  function automatic logic [3:0] lfsr_next(input logic [3:0] r);
    return (r == LFSR_LOCK) ? LFSR_SEED : {r[2:0], ~(r[3] ^ r[2])};
  endfunction

endpackage

// File: rtl/card_dealer_lfsr.sv
// 4-bit XNOR LFSR (period 15) with seed on reset and lockup recovery.
module lfsr4_xnor
  import dealer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  output logic [3:0] value
);

  logic [3:0] value_q;
  logic [3:0] value_d;

  always_comb begin
    value_d = value_q;
    if (step) value_d = lfsr_next(value_q);
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= LFSR_SEED;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/card_dealer.sv
// Deals four card values in 1..MAX_CARD by rejection-sampling a 4-bit LFSR;
// owns the LFSR, the control FSM, slot/draw counters and the card registers.
module card_dealer
  import dealer_pkg::*;
#(
  parameter int MAX_CARD = 13,
  parameter bit FREE_RUN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        deal_req,
  output logic        ready,
  output logic [15:0] cards,
  output logic        valid,
  output logic [4:0]  draws
);

  localparam logic [CARD_W-1:0] MAX_V = CARD_W'(MAX_CARD);

  state_t      state_q, state_d;
  logic [1:0]  slot_q, slot_d;
  logic [4:0]  draws_q, draws_d;
  logic [15:0] cards_q, cards_d;

  logic [3:0]  lfsr_val;
  logic        lfsr_step;
  logic        accept;
  logic        start;

  assign lfsr_step = FREE_RUN || (state_q == DRAW);
  assign accept    = (state_q == DRAW) && (lfsr_val != '0) && (lfsr_val <= MAX_V);
  assign start     = (state_q != DRAW) && deal_req;

  lfsr4_xnor u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (lfsr_step),
    .value (lfsr_val)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (deal_req) state_d = DRAW;
      DRAW:       if (accept && (slot_q == 2'(NUM_CARDS - 1))) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q != DRAW);
    valid = (state_q == DONE);
  end

  // Slot, draw counter and card file; deal_req during DRAW is ignored.
  always_comb begin
    slot_d  = slot_q;
    draws_d = draws_q;
    cards_d = cards_q;
    if (start) begin
      slot_d  = '0;
      draws_d = '0;
    end else if (state_q == DRAW) begin
      if (draws_q != 5'd31) draws_d = draws_q + 5'd1;
      if (accept) begin
        slot_d = slot_q + 2'd1;
        for (int i = 0; i < NUM_CARDS; i++) begin
          if (slot_q == 2'(i)) cards_d[i*CARD_W +: CARD_W] = lfsr_val;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q  <= '0;
      draws_q <= '0;
      cards_q <= '0;
    end else begin
      slot_q  <= slot_d;
      draws_q <= draws_d;
      cards_q <= cards_d;
    end
  end

  assign cards = cards_q;
  assign draws = draws_q;

endmodule

// File: tb/tb_card_dealer.sv
// Directed, table-driven bench for card_dealer with MAX_CARD=13 and MAX_CARD=9.
module tb_card_dealer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b;
  logic        ready_a, ready_b, valid_a, valid_b;
  logic [15:0] cards_a, cards_b;
  logic [4:0]  draws_a, draws_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  card_dealer #(.MAX_CARD(13), .FREE_RUN(1'b0)) dut_a (
    .clk(clk), .rst(rst), .deal_req(req_a),
    .ready(ready_a), .cards(cards_a), .valid(valid_a), .draws(draws_a)
  );

  card_dealer #(.MAX_CARD(9), .FREE_RUN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .deal_req(req_b),
    .ready(ready_b), .cards(cards_b), .valid(valid_b), .draws(draws_b)
  );

  typedef struct {
    string       name;
    bit          sel_b;
    bit          do_reset;
    bit          force_lock;
    int          pulse_at;
    logic [15:0] exp_cards;
    logic [4:0]  exp_draws;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic get_ready(input bit b);
    return b ? ready_b : ready_a;
  endfunction
  function automatic logic get_valid(input bit b);
    return b ? valid_b : valid_a;
  endfunction
  function automatic logic [15:0] get_cards(input bit b);
    return b ? cards_b : cards_a;
  endfunction
  function automatic logic [4:0] get_draws(input bit b);
    return b ? draws_b : draws_a;
  endfunction

  task automatic set_req(input bit b, input logic v);
    if (b) req_b = v;
    else   req_a = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string nm, input bit b);
    check({nm, "_ready"}, 32'(get_ready(b)), 32'd1);
    check({nm, "_valid"}, 32'(get_valid(b)), 32'd0);
    check({nm, "_cards"}, 32'(get_cards(b)), 32'h0);
    check({nm, "_draws"}, 32'(get_draws(b)), 32'd0);
  endtask

  // Request a hand and wait (bounded) for valid; latency counts edges from the request edge.
  task automatic run_hand(input vec_t v);
    int lat;
    bit timeout;
    @(negedge clk);
    if (v.force_lock) force dut_a.u_lfsr.value_q = 4'hF;
    set_req(v.sel_b, 1'b1);
    @(negedge clk);
    set_req(v.sel_b, 1'b0);
    if (v.force_lock) release dut_a.u_lfsr.value_q;
    lat = 1;
    timeout = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (get_valid(v.sel_b)) begin
        timeout = 1'b0;
        break;
      end
      check({v.name, "_ready_in_draw"}, 32'(get_ready(v.sel_b)), 32'd0);
      set_req(v.sel_b, (lat == v.pulse_at) ? 1'b1 : 1'b0);
      @(negedge clk);
      lat++;
    end
    set_req(v.sel_b, 1'b0);
    check({v.name, "_timeout"}, 32'(timeout), 32'd0);
    check({v.name, "_cards"}, 32'(get_cards(v.sel_b)), 32'(v.exp_cards));
    check({v.name, "_draws"}, 32'(get_draws(v.sel_b)), 32'(v.exp_draws));
    check({v.name, "_latency"}, 32'(lat), 32'(v.exp_draws) + 32'd1);
    check({v.name, "_ready_done"}, 32'(get_ready(v.sel_b)), 32'd1);
  endtask

  initial begin
    rst   = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;

    //          name         b  rst frc pulse cards     draws
    vecs[0] = '{"hand1_m13", 0, 1,  0,  -1,   16'h184A, 5'd5};
    vecs[1] = '{"hand2_m13", 0, 0,  0,  -1,   16'hBD73, 5'd5};
    vecs[2] = '{"hand3_m13", 0, 0,  0,  -1,   16'h29C6, 5'd4};
    vecs[3] = '{"hand4_m13", 0, 0,  0,  -1,   16'h84A5, 5'd4};
    vecs[4] = '{"hand_m9",   1, 1,  0,  -1,   16'h3184, 5'd6};
    vecs[5] = '{"mid_req",   0, 1,  0,  2,    16'h184A, 5'd5};
    vecs[6] = '{"lockup",    0, 1,  1,  -1,   16'h184A, 5'd6};

    do_reset();
    check_reset_state("reset_a", 1'b0);
    check_reset_state("reset_b", 1'b1);

    foreach (vecs[i]) begin
      if (vecs[i].do_reset) do_reset();
      run_hand(vecs[i]);
    end

    // Reset on the third DRAW cycle must abort the hand cleanly.
    do_reset();
    @(negedge clk);
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_draw_partial_draws", 32'(draws_a), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("mid_draw_rst", 1'b0);
    run_hand('{"after_rst", 0, 0, 0, -1, 16'h184A, 5'd5});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/card_dealer.md
# card_dealer

Deals one hand of four card values for the 24 game by sequencing a 4-bit XNOR LFSR and rejecting out-of-range samples. Sits between the game-control FSM (which requests a new hand) and the display/scoring logic (which consumes the four card values). Owns the LFSR instance, so reset, stepping and lockup recovery are centralised here.

## Interface
- MAX_CARD, 13: highest legal card value; legal range 1..MAX_CARD; must be 1..15.
- FREE_RUN, 0: 1 = LFSR also steps every IDLE/DONE cycle (player timing adds entropy); 0 = steps only while drawing (deterministic).
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- deal_req  in  1  one-cycle request for a new hand.
- ready  out  1  high when a deal_req will be accepted (state IDLE or DONE).
- cards  out  16  four 4-bit values; card0 = [3:0], card1 = [7:4], card2 = [11:8], card3 = [15:12].
- valid  out  1  cards holds a complete hand.
- draws  out  5  number of LFSR samples taken for the current/last hand, saturating at 31.

## Operation
- States: IDLE, DRAW, DONE.
- Reset: state IDLE, LFSR = 4'b1010, cards = 0, slot index = 0, draws = 0, valid = 0, ready = 1.
- IDLE: deal_req=1 -> DRAW; clear slot index and draws. Cards are not cleared.
- DRAW: each cycle, sample the current LFSR value v, step the LFSR, draws += 1 (saturating).
  - 1 <= v <= MAX_CARD: write v into cards[slot], slot += 1.
  - v = 0 or v > MAX_CARD: discard, slot unchanged.
  - Acceptance of the fourth card -> DONE in the same edge.
- DONE: valid = 1, cards stable. deal_req=1 -> DRAW, valid drops on that edge, slot/draws cleared.
- deal_req while in DRAW is ignored; it is not queued.
- LFSR step: next = {r[2:0], ~(r[3]^r[2])}. Period 15; 4'b1111 is the lockup state. If the register ever holds 1111, the next step loads 1010 instead.
- Sequence from seed 1010: 10,4,8,0,1,3,7,14,13,11,6,12,9,2,5, then repeats.
- Termination: every 15-cycle period contains value 1, so a hand completes within at most 60 DRAW cycles for any legal MAX_CARD.
- rst in any state, including mid-DRAW, overrides all other inputs and returns to the reset values.
- Duplicate card values are legal and are not filtered.

## Timing
- deal_req sampled at edge N in IDLE/DONE -> first sample at edge N+1.
- Each DRAW cycle consumes exactly one sample; cards[slot] updates at the sampling edge.
- valid rises at the edge that accepts the fourth card. Latency from deal_req = draws + 1 edges (minimum 5).
- ready = (state != DRAW), combinational from state.
- With FREE_RUN=1, the LFSR steps every cycle in every state. Otherwise it holds in IDLE and DONE.

## Structure
- Package dealer_pkg holds:
  - state enum {IDLE, DRAW, DONE};
  - LFSR_SEED = 4'b1010;
  - LFSR_LOCK = 4'b1111;
  - NUM_CARDS = 4;
  - CARD_W = 4.
- Sub-module lfsr4_xnor, posedge-clocked, with ports clk, rst, step, value[3:0].
  - Implements the seed on reset, the XNOR step and lockup recovery.
- Control FSM, slot counter, draws counter and card register file live in card_dealer.

## Test plan
- Reset, FREE_RUN=0, MAX_CARD=13, deal_req at edge 0 -> samples 10,4,8,0,1.
  - Required: cards = {1,8,4,10} (card3..card0), i.e. 16'h184A; valid high after edge 5; draws = 5.
- Second deal_req from DONE -> samples 3,7,14,13,11.
  - Required: 14 rejected; cards = 16'hBD73; draws = 5; valid low during DRAW.
- MAX_CARD=9 from reset -> samples 10(rej),4,8,0(rej),1,3.
  - Required: cards = 16'h3184; draws = 6.
- deal_req pulsed mid-DRAW -> ignored; hand and draws identical to the single-request case.
- rst asserted on the third DRAW cycle -> next cycle: IDLE, cards = 0, valid = 0, draws = 0.
  - A following deal_req reproduces 16'h184A.
- Force the LFSR to 1111 (via the bench hierarchy) in IDLE, then deal.
  - Required: first sample 15 rejected with MAX_CARD=13; next sample is 10; dealing continues without lockup.
